// File: rtl/src_pkg.sv
// src_pkg: shared widths, IR field positions, opcodes and branch condition encodings for the SRC datapath.
package src_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 9;
  localparam int RAM_DEPTH = 512;
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 27;
  localparam int RA_MSB    = 26;
  localparam int RA_LSB    = 23;
  localparam int RB_MSB    = 22;
  localparam int RB_LSB    = 19;
  localparam int RC_MSB    = 18;
  localparam int RC_LSB    = 15;
  localparam int C_MSB     = 18;
  localparam int COND_MSB  = 20;
  localparam int COND_LSB  = 19;

  typedef enum logic [4:0] {
    OP_LD  = 5'b00000,
    OP_LDI = 5'b00001,
    OP_ST  = 5'b00010,
    OP_ADD = 5'b00011,
    OP_SUB = 5'b00100,
    OP_AND = 5'b00101,
    OP_OR  = 5'b00110
  } opcode_e;

  typedef enum logic [1:0] {
    COND_ZERO = 2'b00,
    COND_NZ   = 2'b01,
    COND_POS  = 2'b10,
    COND_NEG  = 2'b11
  } cond_e;

  function automatic logic con_eval(input cond_e cond, input logic [DATA_W-1:0] bus);
    return cond == COND_ZERO ? (bus == '0) :
           cond == COND_NZ   ? (bus != '0) :
           cond == COND_POS  ? (!bus[DATA_W-1] && bus != '0) : bus[DATA_W-1];
  endfunction
endpackage

// File: rtl/src_ram.sv
// src_ram: word RAM with synchronous write and combinational read, contents survive reset.
module src_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int RAM_DEPTH = 512
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [RAM_DEPTH];

  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_addr] <= i_wdata;

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/src_datapath.sv
// src_datapath: single-bus SRC datapath; every register transfer is steered by control-unit strobes.
module src_datapath
  import src_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int RAM_DEPTH = 512
) (
  input  logic              Clock,
  input  logic              Clear,
  output logic [DATA_W-1:0] outp,
  output logic              BranchMet,
  input  logic              PCout,
  input  logic              Zhiout,
  input  logic              Zlowout,
  input  logic              MDRout,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              InPortout,
  input  logic              MARin,
  input  logic              Zin,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              IRin,
  input  logic              Yin,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              OutPortin,
  input  logic              IncPC,
  input  logic              Read,
  input  logic              Write,
  input  logic              ReadEn,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              Rin,
  input  logic              Rout,
  input  logic              BAout,
  input  logic              Cout,
  input  logic              CONIn,
  input  logic              Strobe,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic [DATA_W-1:0] InPort_data,
  input  logic              SUB,
  input  logic              AND,
  input  logic              ADD
);
  logic [DATA_W-1:0]   r_gpr [16];
  logic [DATA_W-1:0]   r_pc, r_ir, r_mdr, r_y, r_hi, r_lo, r_inport, r_outp;
  logic [2*DATA_W-1:0] r_z;
  logic [ADDR_W-1:0]   r_mar;
  logic                r_con;
  logic [3:0]          w_idx;
  logic [DATA_W-1:0]   w_gpr_bus, w_c, w_bus, w_alu, w_ram_rdata, w_mdr_d;
  logic [4:0]          w_opcode_unused;

  assign w_opcode_unused = r_ir[OP_MSB:OP_LSB];
  assign w_idx = Gra ? r_ir[RA_MSB:RA_LSB] : Grb ? r_ir[RB_MSB:RB_LSB] : Grc ? r_ir[RC_MSB:RC_LSB] : 4'd0;
  assign w_gpr_bus = (BAout && w_idx == 4'd0) ? '0 : r_gpr[w_idx];
  assign w_c = {{(DATA_W-C_MSB-1){r_ir[C_MSB]}}, r_ir[C_MSB:0]};

  assign w_bus = (Rout || BAout) ? w_gpr_bus :
                 PCout     ? r_pc :
                 Zhiout    ? r_z[2*DATA_W-1:DATA_W] :
                 Zlowout   ? r_z[DATA_W-1:0] :
                 HIout     ? r_hi :
                 LOout     ? r_lo :
                 MDRout    ? r_mdr :
                 InPortout ? r_inport :
                 Cout      ? w_c : '0;

  assign w_alu = IncPC ? w_bus + 1'b1 :
                 ADD   ? r_y + w_bus :
                 SUB   ? r_y - w_bus :
                 AND   ? r_y & w_bus : w_bus;

  assign w_mdr_d = Read ? (ReadEn ? w_ram_rdata : Mdatain) : w_bus;

  // RAM sees the pre-edge MDR, so a same-cycle MDRin does not affect what is written
  src_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH)) u_ram (
    .i_clk  (Clock),
    .i_we   (Write),
    .i_addr (r_mar),
    .i_wdata(r_mdr),
    .o_rdata(w_ram_rdata)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_pc     <= '0;
      r_ir     <= '0;
      r_mar    <= '0;
      r_mdr    <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_inport <= '0;
      r_outp   <= '0;
      r_con    <= 1'b0;
    end else begin
      if (Rin)       r_gpr[w_idx] <= w_bus;
      if (PCin)      r_pc <= w_bus;
      if (IRin)      r_ir <= w_bus;
      if (MARin)     r_mar <= w_bus[ADDR_W-1:0];
      if (MDRin)     r_mdr <= w_mdr_d;
      if (Yin)       r_y <= w_bus;
      if (Zin)       r_z <= {{DATA_W{w_alu[DATA_W-1]}}, w_alu};
      if (HIin)      r_hi <= w_bus;
      if (LOin)      r_lo <= w_bus;
      if (Strobe)    r_inport <= InPort_data;
      if (OutPortin) r_outp <= w_bus;
      if (CONIn)     r_con <= con_eval(cond_e'(r_ir[COND_MSB:COND_LSB]), w_bus);
    end
  end

  assign outp      = r_outp;
  assign BranchMet = r_con;
endmodule

// File: tb/tb_src_datapath.sv
// tb_src_datapath: scoreboard bench walking the SRC datapath through store, fetch, ALU, CON and reset sequences.
module tb_src_datapath;
  logic        Clock = 1'b0, Clear = 1'b0;
  logic [31:0] outp;
  logic        BranchMet;
  logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
  logic IncPC, Read, Write, ReadEn, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;
  logic SUB, AND, ADD;
  logic [31:0] Mdatain, InPort_data;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;

  src_datapath dut (
    .Clock(Clock), .Clear(Clear), .outp(outp), .BranchMet(BranchMet),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .ReadEn(ReadEn), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONIn(CONIn),
    .Strobe(Strobe), .Mdatain(Mdatain), .InPort_data(InPort_data), .SUB(SUB), .AND(AND),
    .ADD(ADD)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic [63:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic pop(input logic [63:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL sb_empty: got no expectation, expected one queued");
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic idle();
    {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin} = '0;
    {IncPC, Read, Write, ReadEn, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe} = '0;
    {SUB, AND, ADD} = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1; step();
  endtask

  task automatic load_ir(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; IRin = 1; step();
  endtask

  initial begin
    idle();
    Mdatain = '0;
    InPort_data = '0;
    #2;
    push("rst_outp", 0); push("rst_con", 0); push("rst_pc", 0);
    pop(64'(outp)); pop(64'(BranchMet)); pop(64'(dut.r_pc));
    @(negedge Clock) Clear = 1;

    load_mdr(85);
    push("mdr_85", 85); pop(64'(dut.r_mdr));
    MDRout = 1; MARin = 1; push("mar_85", 85); step(); pop(64'(dut.r_mar));
    load_mdr(15);
    Write = 1; Mdatain = 77; Read = 1; MDRin = 1;
    push("ram_old_mdr", 15); push("mdr_new", 77);
    step(); pop(64'(dut.u_ram.r_mem[85])); pop(64'(dut.r_mdr));
    Read = 1; ReadEn = 1; MDRin = 1; push("mdr_from_ram", 15); step(); pop(64'(dut.r_mdr));

    load_ir(32'h0080_0000);
    push("ir_load", 32'h0080_0000); pop(64'(dut.r_ir));
    load_mdr(10);
    MDRout = 1; Gra = 1; Rin = 1; push("r1_10", 10); step(); pop(64'(dut.r_gpr[1]));
    load_ir(0);
    load_mdr(0);
    MDRout = 1; Gra = 1; Rin = 1; push("r0_0", 0); step(); pop(64'(dut.r_gpr[0]));
    load_mdr(7);
    MDRout = 1; Gra = 1; Rin = 1; step();
    Gra = 1; Rout = 1; OutPortin = 1; push("r0_rout", 7); step(); pop(64'(outp));
    Gra = 1; BAout = 1; OutPortin = 1; push("r0_baout", 0); step(); pop(64'(outp));

    PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
    push("fetch_mar", 0); push("fetch_z", 1);
    step(); pop(64'(dut.r_mar)); pop(dut.r_z);
    Zlowout = 1; PCin = 1; push("pc_inc", 1); step(); pop(64'(dut.r_pc));
    load_ir(32'h1080_0055);
    push("ir_st", 32'h1080_0055); pop(64'(dut.r_ir));

    Grb = 1; BAout = 1; Yin = 1; push("st_y", 0); step(); pop(64'(dut.r_y));
    Cout = 1; ADD = 1; Zin = 1; push("st_z", 85); step(); pop(dut.r_z);
    Zlowout = 1; MARin = 1; push("st_mar", 85); step(); pop(64'(dut.r_mar));
    Gra = 1; Rout = 1; MDRin = 1; push("st_mdr", 10); step(); pop(64'(dut.r_mdr));
    Write = 1; push("st_ram", 10); step(); pop(64'(dut.u_ram.r_mem[85]));

    Cout = 1; SUB = 1; Zin = 1; push("sub_neg", 64'hFFFF_FFFF_FFFF_FFAB); step(); pop(dut.r_z);
    Zhiout = 1; OutPortin = 1; push("zhi_out", 32'hFFFF_FFFF); step(); pop(64'(outp));
    Gra = 1; Rout = 1; Yin = 1; step();
    Cout = 1; ADD = 1; Zin = 1; push("add_95", 95); step(); pop(dut.r_z);
    Cout = 1; AND = 1; Zin = 1; push("and_0", 0); step(); pop(dut.r_z);
    MDRout = 1; HIin = 1; step();
    HIout = 1; OutPortin = 1; push("hi_out", 10); step(); pop(64'(outp));

    load_ir(32'h0100_0000);
    Gra = 1; Rout = 1; CONIn = 1; push("con_eq0", 1); step(); pop(64'(BranchMet));
    load_ir(32'h0118_0000);
    load_mdr(5);
    MDRout = 1; CONIn = 1; push("con_neg_5", 0); step(); pop(64'(BranchMet));
    load_ir(32'h0008_0000);
    MDRout = 1; CONIn = 1; push("con_nz_5", 1); step(); pop(64'(BranchMet));
    load_ir(32'h0017_FFFF);
    Cout = 1; CONIn = 1; push("con_pos_m1", 0); step(); pop(64'(BranchMet));
    Cout = 1; OutPortin = 1; push("c_sext", 32'hFFFF_FFFF); step(); pop(64'(outp));
    load_ir(32'h001F_FFFF);
    Cout = 1; CONIn = 1; push("con_neg_m1", 1); step(); pop(64'(BranchMet));
    InPort_data = 32'h0000_1234; Strobe = 1; step();
    InPortout = 1; OutPortin = 1; push("inport", 32'h1234); step(); pop(64'(outp));

    #2 Clear = 0;
    #1;
    push("clr_pc", 0); push("clr_ir", 0); push("clr_mar", 0);
    push("clr_z", 0); push("clr_outp", 0); push("clr_con", 0);
    pop(64'(dut.r_pc)); pop(64'(dut.r_ir)); pop(64'(dut.r_mar));
    pop(dut.r_z); pop(64'(outp)); pop(64'(BranchMet));
    #1 Clear = 1;
    push("ram_kept", 10); pop(64'(dut.u_ram.r_mem[85]));
    load_mdr(85);
    MDRout = 1; MARin = 1; step();
    Read = 1; ReadEn = 1; MDRin = 1; step();
    MDRout = 1; OutPortin = 1; push("ram_kept_read", 10); step(); pop(64'(outp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/src_datapath.md
Name: src_datapath

Overview:
- Bus-based 32-bit datapath of the SRC-style teaching CPU (phase 2).
- Contains R0–R15, PC, IR, MAR, MDR, Y, Z (64-bit), HI, LO, the in-port and out-port, a CON branch flip-flop, an internal word RAM, select-and-encode logic and a small ALU.
- Every transfer is steered by external control-unit strobes, one register transfer per clock.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 9, RAM address width (MAR[8:0] used).
- RAM_DEPTH, 512, RAM words.

Ports:
- Clock in 1: system clock; all registers load on its rising edge.
- Clear in 1: asynchronous, active-low reset.
- outp out 32: out-port register.
- BranchMet out 1: CON flip-flop.
- PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout in 1 each: drive bus from the named register.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin in 1 each: load the named register.
- IncPC in 1: ALU computes bus+1.
- Read in 1: MDR source is memory side instead of bus.
- Write in 1: RAM write.
- ReadEn in 1: memory-side MDR source is RAM instead of Mdatain.
- Gra, Grb, Grc in 1 each: select the Ra/Rb/Rc field of IR.
- Rin in 1: write the selected GPR.
- Rout in 1: drive the selected GPR onto the bus.
- BAout in 1: drive the selected GPR onto the bus, with R0 reading as 0.
- Cout in 1: drive sign-extended C onto the bus.
- CONIn in 1: load the CON flip-flop.
- Strobe in 1: capture InPort_data into the in-port register.
- Mdatain in 32: external memory data.
- InPort_data in 32: external input device data.
- SUB, AND, ADD in 1 each: ALU operation selects.

Behaviour:
- Reset (Clear=0, async):
  - All registers, CON and outp clear to 0.
  - RAM contents are not cleared.
- IR fields:
  - opcode = IR[31:27]
  - Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15]
  - C = IR[18:0] sign-extended to 32 bits
  - cond = IR[20:19]
- Select-and-encode:
  - Index = Ra if Gra, else Rb if Grb, else Rc if Grc, else 0.
  - Rin writes R[index] from the bus.
  - Rout drives R[index].
  - BAout drives R[index], or 0 when index=0.
- R0 is a normal storage register; only BAout forces it to 0.
- Bus:
  - Combinational one-hot mux.
  - Fixed priority: Rout/BAout, PCout, Zhiout, Zlowout, HIout, LOout, MDRout, InPortout, Cout.
  - Bus = 0 when no source is asserted.
- ALU (combinational, A=Y, B=bus), 64-bit result, priority:
  - IncPC: B+1.
  - ADD: A+B.
  - SUB: A−B.
  - AND: A&B.
  - Otherwise: B.
  - Upper 32 bits are the sign extension of the 32-bit result.
  - Zin captures the result into Z; Zhiout drives Z[63:32], Zlowout drives Z[31:0].
- MDR on MDRin:
  - Read=1, ReadEn=1: loads RAM[MAR].
  - Read=1, ReadEn=0: loads Mdatain.
  - Read=0: loads the bus.
- MAR loads bus[8:0] on MARin.
- Write=1 writes MDR into RAM[MAR] at the clock edge. When Write and an MDRin load occur in the same cycle, the old MDR is written.
- CON (on CONIn), from the bus value:
  - cond 00: bus==0.
  - cond 01: bus!=0.
  - cond 10: bus>=0 and !=0, signed.
  - cond 11: bus<0.
  - BranchMet = CON.
- OutPortin loads outp from the bus. Strobe loads the in-port register from InPort_data.
- Multiple load enables in the same cycle all load the same bus value.

Decomposition:
- Package src_pkg holds:
  - IR field bit positions
  - opcode constants (ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, ...)
  - cond encodings
  - DATA_W
- One natural sub-module, src_ram: synchronous-write, combinational-read 512x32 RAM.

Test Plan:
- Preset RAM, then store:
  - Mdatain=85, Read+MDRin, then MDRout+MARin: MAR=85.
  - Mdatain=15, Read+MDRin, then Write: RAM[85]=15.
- IR load and GPR write:
  - IR=0x00800000, then MDR=10 with MDRout+Gra+Rin: R1=10.
  - IR=0, then MDR=0 with Gra+Rin: R0=0.
- Instruction fetch:
  - PCout+MARin+IncPC+Zin: MAR=0, Z=1.
  - Zlowout+PCin, then Read+MDRin with Mdatain=0x10800055, then MDRout+IRin: PC=1, IR=0x10800055.
- st R1,85(R0):
  - Grb+BAout+Yin: Y=0.
  - Cout+ADD+Zin: Z=85.
  - Zlowout+MARin: MAR=85.
  - Gra+Rout+MDRin: MDR=10.
  - Write: RAM[85]=10, overwriting 15.
- CON:
  - IR cond=00 with R2=0 driven on bus and CONIn: BranchMet=1.
  - cond=11 with bus=5: BranchMet=0.
- Reset:
  - Clear low mid-sequence: PC, IR, MAR, Z, outp, BranchMet all 0 immediately, without a clock.
  - RAM[85] still 10 afterwards.
